bit_serial_subtractor: RTL and testbench

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

---
 rtl/bit_serial_subtractor.sv | 78 +++++++
 tb/tb_bit_serial_subtractor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// LSB-first serial subtractor; done pulses WIDTH+1 cycles after the accepting edge, then one ready cycle.
// Backpressure: start is honoured only in IDLE; it and a/b are ignored while an operation is in flight.
module bit_serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             br_nxt;

   assign d_bit  = a_sr[0] ^ b_sr[0] ^ br;
   assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

   // ready/done are registered copies of the state, so they trail it by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ready  <= 1'b1;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         br     <= 1'b0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
      end else begin
         ready <= (state == IDLE);
         done  <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= {d_bit, res_sr[WIDTH-1:1]};
               br     <= br_nxt;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1))
                  state <= DONE;
            end
            DONE: begin
               diff   <= res_sr;
               borrow <= br;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Bench for bit_serial_subtractor: transaction-timing reference model checked every cycle,
// plus directed cases with hand-computed results.
module tb_bit_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   bit_serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .done  (done),
      .diff  (diff),
      .borrow(borrow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted start at edge k yields done after edge k+W+1
   // with (a-b) mod 2^W and a<b, and a new start may be accepted at edge k+W+2.
   logic         m_ready, m_done, m_borrow, pb;
   logic [W-1:0] m_diff, pd;
   bit           busy = 1'b0;
   int           cyc = 0;
   int           acc = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_ready  = 1'b1;
         m_done   = 1'b0;
         m_diff   = '0;
         m_borrow = 1'b0;
         busy     = 1'b0;
      end else begin
         m_done = 1'b0;
         if (busy) begin
            int rel;
            rel     = cyc - acc;
            m_ready = 1'b0;
            if (rel == W + 1) begin
               m_done   = 1'b1;
               m_diff   = pd;
               m_borrow = pb;
            end
            if (rel == W + 2) begin
               busy    = 1'b0;
               m_ready = 1'b1;
            end
         end
         if (!busy && start) begin
            busy = 1'b1;
            acc  = cyc;
            pd   = a - b;
            pb   = (a < b);
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", 32'(ready), 32'(m_ready));
         chk("done", 32'(done), 32'(m_done));
         chk("diff", 32'(diff), 32'(m_diff));
         chk("borrow", 32'(borrow), 32'(m_borrow));
      end
   end

   task automatic wait_done(output int lat, output bit ok);
      ok  = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            ok  = 1'b1;
            break;
         end
      end
      if (!ok) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [W-1:0] ed, input logic eb);
      int lat;
      bit ok;
      a     = xa;
      b     = xb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      wait_done(lat, ok);
      if (ok) begin
         chk("latency", 32'(lat + 1), 32'd10);
         chk("lit_diff", 32'(diff), 32'(ed));
         chk("lit_borrow", 32'(borrow), 32'(eb));
         chk("model_diff", 32'(m_diff), 32'(ed));
      end
      @(negedge clk);
      chk("ready_back", 32'(ready), 32'd1);
   endtask

   initial begin
      int lat, pulses, first, prev, gap_bad;
      bit ok;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(8'h2A, 8'h0F, 8'h1B, 1'b0);
      run_op(8'h05, 8'h07, 8'hFE, 1'b1);
      run_op(8'h00, 8'hFF, 8'h01, 1'b1);
      run_op(8'h80, 8'h01, 8'h7F, 1'b0);
      run_op(8'h00, 8'h00, 8'h00, 1'b0);

      // second start during SHIFT must be ignored
      a = 8'h10; b = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, ok);
      if (ok) begin
         chk("ign_diff", 32'(diff), 32'h0F);
         chk("ign_borrow", 32'(borrow), 32'd0);
      end
      pulses = 0;
      repeat (14) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("ign_no_extra_done", 32'(pulses), 32'd0);

      // reset sampled on the 4th SHIFT edge aborts the operation
      a = 8'h77; b = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_borrow", 32'(borrow), 32'd0);
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'd0);
      run_op(8'h09, 8'h03, 8'h06, 1'b0);

      // start held high: one operation every W+2 cycles
      a = 8'h03; b = 8'h01; start = 1'b1;
      pulses = 0; first = 0; prev = 0; gap_bad = 0;
      for (int i = 1; i <= 31; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (pulses == 1) first = i;
            else if (i - prev != 10) gap_bad++;
            prev = i;
            chk("b2b_diff", 32'(diff), 32'h02);
            chk("b2b_borrow", 32'(borrow), 32'd0);
         end
      end
      start = 1'b0;
      chk("b2b_pulses", 32'(pulses), 32'd3);
      chk("b2b_first", 32'(first), 32'd10);
      chk("b2b_gap", 32'(gap_bad), 32'd0);
      repeat (12) @(negedge clk);

      // randomized traffic with occasional resets
      for (int i = 0; i < 2000; i++) begin
         start = ($urandom_range(0, 2) == 0);
         a     = W'($urandom);
         b     = W'($urandom);
         rst   = ($urandom_range(0, 79) == 0);
         @(negedge clk);
      end
      start = 1'b0;
      rst   = 1'b0;
      repeat (12) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
